// File: rtl/lz77_encoder_if.sv
// Byte-in / codeword-out bundle for the LZ77 encoder.
// master = byte source and codeword consumer; slave = the encoder itself.
interface lz77_encoder_if;
    logic [7:0] chardata;
    logic       in_valid;
    logic       in_ready;
    logic       valid;
    logic       encode;
    logic [3:0] offset;
    logic [2:0] match_len;
    logic [7:0] char_nxt;
    logic       finish;

    modport master (
        output chardata, in_valid,
        input  in_ready, valid, encode, offset, match_len, char_nxt, finish
    );

    modport slave (
        input  chardata, in_valid,
        output in_ready, valid, encode, offset, match_len, char_nxt, finish
    );
endinterface

// File: rtl/lz77_encoder.sv
// LZ77 encoder: 9-byte search window, 8-byte look-ahead, one candidate offset per cycle.
// Emits (offset, match_len, char_nxt) codewords until the '$' terminator is coded.
module lz77_encoder (
    input  logic          clk,
    input  logic          reset,
    lz77_encoder_if.slave bus
);
    localparam logic [7:0] END_CHAR = 8'h24;

    typedef enum logic [2:0] {FILL, SEARCH, EMIT, SHIFT, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] sb_q [9];
    logic [7:0] sb_d [9];
    logic [7:0] la_q [8];
    logic [7:0] la_d [8];
    logic [3:0] count_q, count_d;
    logic       dollar_q, dollar_d;
    logic [3:0] pos_q, pos_d;
    logic [2:0] best_len_q, best_len_d;
    logic [3:0] best_off_q, best_off_d;
    logic [2:0] shift_q, shift_d;
    logic [3:0] offset_q, offset_d;
    logic [2:0] len_q, len_d;
    logic [7:0] char_q, char_d;
    logic       finish_q, finish_d;

    logic [7:0] window [16];
    logic [2:0] cap_len;
    logic [2:0] cand_len;
    logic       run;
    logic [3:0] src_idx;
    logic       transfer;

    assign bus.in_ready  = !reset && (state_q == FILL) && (count_q < 4'd8) && !dollar_q;
    assign bus.valid     = (state_q == EMIT);
    assign bus.encode    = !reset;
    assign bus.offset    = offset_q;
    assign bus.match_len = len_q;
    assign bus.char_nxt  = char_q;
    assign bus.finish    = finish_q;
    assign transfer      = bus.in_ready && bus.in_valid;

    // Oldest search entry first, then the look-ahead, so a candidate source
    // may run past the search buffer into the look-ahead (overlapping match).
    always_comb begin
        for (int j = 0; j < 9; j++) begin
            window[j] = sb_q[8 - j];
        end
        for (int j = 0; j < 7; j++) begin
            window[9 + j] = la_q[j];
        end
    end

    always_comb begin
        cap_len  = (count_q == 4'd0) ? 3'd0 : 3'(count_q - 4'd1);
        cand_len = 3'd0;
        run      = 1'b1;
        src_idx  = 4'd0;
        for (int k = 0; k < 7; k++) begin
            src_idx = 4'd8 - pos_q + 4'(k);
            if (run && (3'(k) < cap_len) && (window[src_idx] == la_q[k])) begin
                cand_len = cand_len + 3'd1;
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sb_d       = sb_q;
        la_d       = la_q;
        count_d    = count_q;
        dollar_d   = dollar_q;
        pos_d      = pos_q;
        best_len_d = best_len_q;
        best_off_d = best_off_q;
        shift_d    = shift_q;
        offset_d   = offset_q;
        len_d      = len_q;
        char_d     = char_q;
        finish_d   = finish_q;

        case (state_q)
            FILL: begin
                pos_d      = 4'd0;
                best_len_d = 3'd0;
                best_off_d = 4'd0;
                if (dollar_q || (count_q == 4'd8)) begin
                    state_d = SEARCH;
                end else if (transfer) begin
                    la_d[count_q[2:0]] = bus.chardata;
                    count_d            = count_q + 4'd1;
                    if (bus.chardata == END_CHAR) begin
                        dollar_d = 1'b1;
                    end
                    if ((count_q == 4'd7) || (bus.chardata == END_CHAR)) begin
                        state_d = SEARCH;
                    end
                end
            end

            SEARCH: begin
                if (cand_len > best_len_q) begin
                    best_len_d = cand_len;
                    best_off_d = pos_q;
                end
                pos_d = pos_q + 4'd1;
                if (pos_q == 4'd8) begin
                    state_d  = EMIT;
                    offset_d = best_off_d;
                    len_d    = best_len_d;
                    char_d   = la_q[best_len_d];
                end
            end

            EMIT: begin
                state_d = SHIFT;
                shift_d = len_q;
                if (char_q == END_CHAR) begin
                    finish_d = 1'b1;
                end
            end

            SHIFT: begin
                sb_d[0] = la_q[0];
                for (int j = 1; j < 9; j++) begin
                    sb_d[j] = sb_q[j - 1];
                end
                for (int j = 0; j < 7; j++) begin
                    la_d[j] = la_q[j + 1];
                end
                la_d[7] = 8'h00;
                count_d = count_q - 4'd1;
                if (shift_q == 3'd0) begin
                    state_d = (char_q == END_CHAR) ? DONE : FILL;
                end else begin
                    shift_d = shift_q - 3'd1;
                end
            end

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            for (int j = 0; j < 9; j++) begin
                sb_q[j] <= 8'h00;
            end
            for (int j = 0; j < 8; j++) begin
                la_q[j] <= 8'h00;
            end
            count_q    <= 4'd0;
            dollar_q   <= 1'b0;
            pos_q      <= 4'd0;
            best_len_q <= 3'd0;
            best_off_q <= 4'd0;
            shift_q    <= 3'd0;
            offset_q   <= 4'd0;
            len_q      <= 3'd0;
            char_q     <= 8'h00;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sb_q       <= sb_d;
            la_q       <= la_d;
            count_q    <= count_d;
            dollar_q   <= dollar_d;
            pos_q      <= pos_d;
            best_len_q <= best_len_d;
            best_off_q <= best_off_d;
            shift_q    <= shift_d;
            offset_q   <= offset_d;
            len_q      <= len_d;
            char_q     <= char_d;
            finish_q   <= finish_d;
        end
    end
endmodule
